// File: rtl/sb_lsu.sv
// sb_lsu: load/store unit bridging the pipeline's level-held memory request onto a req/gnt/rvalid bus.
// Optional watchdog abort enabled by defining SB_LSU_TIMEOUT_EN.

module sb_lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  byte_sel,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L = LANE[1:0];

  always_comb begin
    be    = 1'b1;
    wbyte = wdata[8*LANE +: 8];
    case (byte_sel)
      2'b00: begin
        be    = (addr_lo == L);
        wbyte = wdata[7:0];
      end
      2'b01: begin
        be    = (addr_lo[1] == L[1]);
        wbyte = L[0] ? wdata[15:8] : wdata[7:0];
      end
      default: ;
    endcase
  end
endmodule

module sb_lsu #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              un_sign_i,
  input  logic [1:0]        byte_sel_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              hold_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]          addr;
    logic [1:0]                 sel;
    logic                       uns;
    logic                       we;
    logic [NUM_LANES-1:0]       be;
    logic [NUM_LANES-1:0][7:0]  wdata;
  } req_t;

  state_t state;
  req_t   rq;

  logic                      access, misaligned, start, timeout;
  logic [NUM_LANES-1:0]      be_d;
  logic [NUM_LANES-1:0][7:0] wdata_d;
  logic [7:0]                byte_v;
  logic [15:0]               half_v;
  logic [DATA_W-1:0]         ext_v;

  assign access     = mem_re_i | mem_we_i;
  assign misaligned = (byte_sel_i == 2'b01) ? addr_i[0]
                    : (byte_sel_i == 2'b00) ? 1'b0
                    : (addr_i[1:0] != 2'b00);
  assign start      = (state == IDLE) && access && !misaligned;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sb_lsu_lane #(.LANE(g)) u_lane (
      .byte_sel (byte_sel_i),
      .addr_lo  (addr_i[1:0]),
      .wdata    (wdata_i),
      .be       (be_d[g]),
      .wbyte    (wdata_d[g])
    );
  end

  // Load lane pick uses the captured address, not the live pipeline one.
  always_comb begin
    byte_v = 8'(bus_rdata_i >> {rq.addr[1:0], 3'b000});
    half_v = rq.addr[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (rq.sel)
      2'b00:   ext_v = {{24{~rq.uns & byte_v[7]}}, byte_v};
      2'b01:   ext_v = {{16{~rq.uns & half_v[15]}}, half_v};
      default: ext_v = bus_rdata_i;
    endcase
  end

`ifdef SB_LSU_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
  logic [TW-1:0] to_cnt;

  assign timeout = ((state == REQ) || (state == WAIT_R)) &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  to_cnt <= '0;
    else if ((state == REQ) || (state == WAIT_R)) to_cnt <= to_cnt + 1'b1;
    else                                      to_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rq            <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (access && misaligned) misalign_o <= 1'b1;
          if (start) begin
            rq <= '{addr: addr_i, sel: byte_sel_i, uns: un_sign_i,
                    we: mem_we_i & ~mem_re_i, be: be_d, wdata: wdata_d};
            state <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            rdata_o   <= '0;
            bus_err_o <= 1'b1;
            state     <= DONE;
          end else if (bus_gnt_i) begin
            state <= rq.we ? DONE : WAIT_R;
          end
        end
        WAIT_R: begin
          if (timeout) begin
            rdata_o   <= '0;
            bus_err_o <= 1'b1;
            state     <= DONE;
          end else if (bus_rvalid_i) begin
            rdata_o       <= ext_v;
            rdata_valid_o <= 1'b1;
            state         <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hold_o      = start || (state == REQ) || (state == WAIT_R);
  assign bus_req_o   = (state == REQ);
  assign bus_we_o    = rq.we;
  assign bus_addr_o  = {rq.addr[ADDR_W-1:2], 2'b00};
  assign bus_be_o    = rq.be;
  assign bus_wdata_o = rq.wdata;
endmodule

// File: tb/tb_sb_lsu.sv
// Bench for sb_lsu: directed test-plan cases followed by random accesses against a rule-level model.
module tb_sb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        un_sign_i;
  logic [1:0]  byte_sel_i;
  logic        mem_re_i, mem_we_i;
  logic [31:0] addr_i, wdata_i;
  logic        hold_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o, misalign_o, bus_err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_rdata = '0;

  sb_lsu dut (
    .clk(clk), .rst(rst), .un_sign_i(un_sign_i), .byte_sel_i(byte_sel_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .hold_o(hold_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sel);
    return (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [1:0] sel, input logic [31:0] a);
    return (a % nbytes(sel)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sel, input logic [31:0] a);
    int n = nbytes(sel);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sel, input logic [31:0] w);
    logic [31:0] r = '0;
    int n = nbytes(sel);
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] sel, input logic [31:0] a,
                                      input logic [31:0] word, input logic uns);
    int n = nbytes(sel);
    logic [63:0] mask = (64'd1 << (8*n)) - 1;
    logic [63:0] v = ({32'b0, word} >> (8*(a % 4))) & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    mem_re_i = 0; mem_we_i = 0;
  endtask

  task automatic do_acc(input logic re, input logic we, input logic [31:0] a,
                        input logic [1:0] sel, input logic uns, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] word);
    @(negedge clk);
    mem_re_i = re; mem_we_i = we; addr_i = a; byte_sel_i = sel;
    un_sign_i = uns; wdata_i = wd;
    #1;
    if (m_mis(sel, a)) begin
      chk("mis_hold", 32'(hold_o), 0);
      chk("mis_req", 32'(bus_req_o), 0);
      @(negedge clk); idle_inputs(); #1;
      chk("mis_pulse", 32'(misalign_o), 1);
      chk("mis_nvalid", 32'(rdata_valid_o), 0);
      chk("mis_req2", 32'(bus_req_o), 0);
      @(negedge clk); #1;
      chk("mis_clear", 32'(misalign_o), 0);
      return;
    end
    chk("idle_hold", 32'(hold_o), 1);
    for (int i = 0; i <= gd; i++) begin
      @(negedge clk); bus_gnt_i = (i == gd); #1;
      chk("req", 32'(bus_req_o), 1);
      chk("req_hold", 32'(hold_o), 1);
      chk("addr", bus_addr_o, {a[31:2], 2'b00});
      chk("be", 32'(bus_be_o), 32'(m_be(sel, a)));
      chk("wdata", bus_wdata_o, m_wd(sel, wd));
      chk("we", 32'(bus_we_o), 32'(we & ~re));
    end
    @(negedge clk); bus_gnt_i = 0;
    if (!re) begin
      #1;
      chk("st_hold", 32'(hold_o), 0);
      chk("st_req", 32'(bus_req_o), 0);
      chk("st_nvalid", 32'(rdata_valid_o), 0);
      chk("st_rdata", rdata_o, exp_rdata);
    end else begin
      for (int i = 0; i <= rd; i++) begin
        if (i > 0) @(negedge clk);
        bus_rvalid_i = (i == rd);
        bus_rdata_i  = (i == rd) ? word : $urandom;
        #1;
        chk("wr_hold", 32'(hold_o), 1);
        chk("wr_req", 32'(bus_req_o), 0);
      end
      @(negedge clk); bus_rvalid_i = 0; bus_rdata_i = $urandom; #1;
      exp_rdata = m_rd(sel, a, word, uns);
      chk("ld_valid", 32'(rdata_valid_o), 1);
      chk("ld_data", rdata_o, exp_rdata);
      chk("ld_hold", 32'(hold_o), 0);
    end
    idle_inputs();
    @(negedge clk); #1;
    chk("idle_nvalid", 32'(rdata_valid_o), 0);
    chk("idle_rdata", rdata_o, exp_rdata);
    chk("idle_req", 32'(bus_req_o), 0);
    chk("idle_err", 32'(bus_err_o), 0);
  endtask

  initial begin
    rst = 1; idle_inputs(); addr_i = '0; wdata_i = '0; byte_sel_i = 2'b10; un_sign_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    #1;
    chk("rst_hold", 32'(hold_o), 0);
    chk("rst_req", 32'(bus_req_o), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_valid", 32'(rdata_valid_o), 0);
    chk("rst_mis", 32'(misalign_o), 0);
    chk("rst_err", 32'(bus_err_o), 0);
    @(negedge clk); @(negedge clk); rst = 0;

    do_acc(0, 1, 32'h100, 2'b10, 0, 32'hDEADBEEF, 0, 0, 0);
    do_acc(1, 0, 32'h203, 2'b00, 0, 32'h0, 0, 0, 32'h80FF1234);
    do_acc(1, 0, 32'h012, 2'b01, 1, 32'h0, 3, 0, 32'hBEEF0000);
    do_acc(1, 0, 32'h102, 2'b10, 0, 32'h0, 0, 0, 0);
    do_acc(1, 1, 32'h044, 2'b11, 0, 32'h11223344, 1, 2, 32'hCAFEF00D);
    do_acc(0, 1, 32'h021, 2'b00, 0, 32'h000000A5, 0, 0, 0);
    do_acc(0, 1, 32'h022, 2'b01, 0, 32'h00001234, 2, 0, 0);

    // reset while a load waits for rvalid; the late rvalid must be dropped
    @(negedge clk);
    mem_re_i = 1; addr_i = 32'h40; byte_sel_i = 2'b10;
    @(negedge clk); bus_gnt_i = 1;
    @(negedge clk); bus_gnt_i = 0; idle_inputs(); rst = 1; #1;
    exp_rdata = '0;
    chk("rstmid_hold", 32'(hold_o), 0);
    chk("rstmid_req", 32'(bus_req_o), 0);
    chk("rstmid_rdata", rdata_o, 0);
    @(negedge clk); rst = 0;
    @(negedge clk); bus_rvalid_i = 1; bus_rdata_i = 32'h12345678;
    @(negedge clk); bus_rvalid_i = 0; #1;
    chk("late_rv_valid", 32'(rdata_valid_o), 0);
    chk("late_rv_rdata", rdata_o, 0);
    chk("late_rv_hold", 32'(hold_o), 0);

    for (int t = 0; t < 60; t++) begin
      logic re, we;
      re = 1'($urandom_range(0, 1));
      we = re ? 1'($urandom_range(0, 1)) : 1'b1;
      do_acc(re, we, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
